// File: rtl/dtw_fifo_pkg.sv
// Shared constants and helpers for DTW blocks.
// Holds default widths and the occupancy-counter width function.
package dtw_fifo_pkg;

  localparam int DTW_DATA_WIDTH = 32;
  localparam int DTW_DEPTH      = 20;

  // Occupancy must represent 0..depth inclusive, hence depth+1 states.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Modulo-DEPTH pointer with enable, synchronous clear and async reset.
// Wraps from DEPTH-1 to 0 for any DEPTH, power of two or not.
module fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dtw_ring_fifo.sv
// Circular-buffer FIFO with registered status flags, sticky error flags
// and a choice of registered or first-word-fall-through read data.
module dtw_ring_fifo
  import dtw_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DTW_DATA_WIDTH,
  parameter int DEPTH      = DTW_DEPTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          wren,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          rden,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  if (DEPTH < 2) begin : g_bad_depth
    $error("dtw_ring_fifo: DEPTH must be at least 2");
  end
  if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("dtw_ring_fifo: need AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  af_q, af_d, ae_q, ae_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  // A full FIFO still takes a write when a read frees a slot that cycle.
  always_comb begin
    rd_acc = rden & ~empty_q & ~clr;
    wr_acc = wren & (~full_q | rd_acc) & ~clr;

    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
    af_d    = (count_d >= CW'(AF_LEVEL));
    ae_d    = (count_d <= CW'(AE_LEVEL));
    ovf_d   = clr ? 1'b0 : (ovf_q | (wren & ~wr_acc));
    unf_d   = clr ? 1'b0 : (unf_q | (rden & empty_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= (AF_LEVEL == 0);
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= i_data;
    end
  end

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (rd_acc),
    .ptr   (rd_ptr)
  );

  if (FWFT != 0) begin : g_fwft
    // Head is gated by empty so o_data reads zero after reset or a flush.
    assign o_data  = empty_q ? '0 : mem[rd_ptr];
    assign o_valid = ~empty_q;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic                  o_valid_q, o_valid_d;

    always_comb begin
      o_data_d  = rd_acc ? mem[rd_ptr] : o_data_q;
      o_valid_d = rd_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        o_data_q  <= '0;
        o_valid_q <= 1'b0;
      end else begin
        o_data_q  <= o_data_d;
        o_valid_q <= o_valid_d;
      end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_dtw_ring_fifo.sv
// Directed bench for dtw_ring_fifo: DEPTH=4, DATA_WIDTH=8, AF=3, AE=1.
// One registered-read and one FWFT instance share the same stimulus.
module tb_dtw_ring_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr, wren, rden;
  logic [7:0] i_data;

  logic [7:0] o_data0, o_data1;
  logic       o_valid0, o_valid1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [2:0] count0, count1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dtw_ring_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(o_data0), .o_valid(o_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  dtw_ring_fifo #(.DATA_WIDTH(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(o_data1), .o_valid(o_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; checks land 1ns after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    wren = w; i_data = d; rden = r; clr = c;
    @(posedge clk);
    #1;
    wren = 1'b0; rden = 1'b0; clr = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] cnt, input logic f,
                           input logic e, input logic a_f, input logic a_e);
    chk({tag, ".count"}, 32'(count0), 32'(cnt));
    chk({tag, ".full"},  32'(full0),  32'(f));
    chk({tag, ".empty"}, 32'(empty0), 32'(e));
    chk({tag, ".af"},    32'(af0),    32'(a_f));
    chk({tag, ".ae"},    32'(ae0),    32'(a_e));
    chk({tag, ".count1"}, 32'(count1), 32'(cnt));
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wren = 1'b0; rden = 1'b0; i_data = 8'h00;
    #7;
    chk_flags("rst", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst.odata0", 32'(o_data0), 32'h0);
    chk("rst.ovalid0", 32'(o_valid0), 32'h0);
    chk("rst.odata1", 32'(o_data1), 32'h0);
    chk("rst.ovalid1", 32'(o_valid1), 32'h0);
    chk("rst.ovf", 32'(ovf0), 32'h0);
    chk("rst.unf", 32'(unf0), 32'h0);
    rst_n = 1'b1;

    // Fill, overflow, then drain in order
    cyc(1'b1, 8'h11, 1'b0, 1'b0);
    chk_flags("w1", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("w1.fwft_data", 32'(o_data1), 32'h11);
    chk("w1.fwft_valid", 32'(o_valid1), 32'h1);
    cyc(1'b1, 8'h22, 1'b0, 1'b0);
    chk_flags("w2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b0);
    chk_flags("w3", 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h44, 1'b0, 1'b0);
    chk_flags("w4", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("w4.ovf", 32'(ovf0), 32'h0);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk_flags("w5", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("w5.ovf", 32'(ovf0), 32'h1);
    chk("w5.ovalid", 32'(o_valid0), 32'h0);
    chk("w5.fwft_head", 32'(o_data1), 32'h11);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rd.data", 32'(o_data0), 32'(8'h11 * (i + 1)));
      chk("rd.valid", 32'(o_valid0), 32'h1);
      chk("rd.count", 32'(count0), 32'(3 - i));
    end
    chk("rd.empty", 32'(empty0), 32'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle.valid", 32'(o_valid0), 32'h0);
    chk("idle.hold", 32'(o_data0), 32'h44);
    chk("idle.ovf_sticky", 32'(ovf0), 32'h1);

    // Flush sticky flags, then streaming read+write while full across wrap
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr.ovf", 32'(ovf0), 32'h0);
    chk("clr.count", 32'(count0), 32'h0);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk_flags("fill", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'(i + 5), 1'b1, 1'b0);
      chk("rw.data", 32'(o_data0), 32'(i + 1));
      chk("rw.valid", 32'(o_valid0), 32'h1);
      chk("rw.count", 32'(count0), 32'h4);
      chk("rw.full", 32'(full0), 32'h1);
    end
    chk("rw.ovf", 32'(ovf0), 32'h0);
    chk("rw.fwft_head", 32'(o_data1), 32'h0B);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain.data", 32'(o_data0), 32'(11 + i));
    end
    chk_flags("drain", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Read+write on empty: write taken, read rejected
    cyc(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("rwe.count", 32'(count0), 32'h1);
    chk("rwe.unf", 32'(unf0), 32'h1);
    chk("rwe.valid", 32'(o_valid0), 32'h0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rwe.data", 32'(o_data0), 32'hA5);
    chk("rwe.valid2", 32'(o_valid0), 32'h1);
    chk("rwe.count2", 32'(count0), 32'h0);

    // FWFT head visible one cycle after write, before any read
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("fwft.data", 32'(o_data1), 32'h5A);
    chk("fwft.valid", 32'(o_valid1), 32'h1);
    chk("fwft.reg_valid", 32'(o_valid0), 32'h0);

    // Flush with a concurrent write discards everything
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk("pre_clr.count", 32'(count0), 32'h3);
    chk("pre_clr.unf", 32'(unf0), 32'h1);
    cyc(1'b1, 8'h88, 1'b0, 1'b1);
    chk_flags("clrw", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clrw.unf", 32'(unf0), 32'h0);
    chk("clrw.ovf", 32'(ovf0), 32'h0);
    chk("clrw.fwft_valid", 32'(o_valid1), 32'h0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0);
    chk("clrw.fwft_new", 32'(o_data1), 32'h99);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("clrw.data", 32'(o_data0), 32'h99);
    chk("clrw.count", 32'(count0), 32'h0);

    // Async reset between edges with three entries queued
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ares.unf_set", 32'(unf0), 32'h1);
    for (int i = 1; i <= 3; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
    chk("ares.pre_count", 32'(count0), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_flags("ares", 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("ares.unf", 32'(unf0), 32'h0);
    chk("ares.odata0", 32'(o_data0), 32'h0);
    chk("ares.odata1", 32'(o_data1), 32'h0);
    chk("ares.ovalid1", 32'(o_valid1), 32'h0);
    rst_n = 1'b1;
    cyc(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("ares.count1", 32'(count0), 32'h1);
    chk("ares.fwft_head", 32'(o_data1), 32'hC3);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ares.data", 32'(o_data0), 32'hC3);
    chk("ares.empty", 32'(empty0), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
